// File: rtl/pwm_fader_pkg.sv
// rtl/pwm_fader_pkg.sv - shared state type for the PWM fader
package pwm_fader_pkg;

  localparam int PHASE_W = 3;

  // Encoding is visible on the phase output, so the values are fixed.
  typedef enum logic [PHASE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_RISE    = 3'd1,
    ST_HOLD_HI = 3'd2,
    ST_FALL    = 3'd3,
    ST_HOLD_LO = 3'd4
  } fader_state_e;

endpackage

// File: rtl/pwm_fader_if.sv
// rtl/pwm_fader_if.sv - control/status bundle between a PWM fader and its host
interface pwm_fader_if #(
  parameter int N      = 8,
  parameter int PRE_W  = 16,
  parameter int HOLD_W = 8
);
  import pwm_fader_pkg::*;

  logic               ena;
  logic [PRE_W-1:0]   prescale;
  logic [N-1:0]       ramp_inc;
  logic [N-1:0]       duty_max;
  logic [HOLD_W-1:0]  hold_cycles;
  logic               step;
  logic [N-1:0]       duty;
  logic               period_done;
  logic [PHASE_W-1:0] phase;

  modport master (
    output ena, prescale, ramp_inc, duty_max, hold_cycles,
    input  step, duty, period_done, phase
  );

  modport slave (
    input  ena, prescale, ramp_inc, duty_max, hold_cycles,
    output step, duty, period_done, phase
  );

endinterface

// File: rtl/pwm_fader_step_divider.sv
// rtl/pwm_fader_step_divider.sv - prescaler producing step strobes and PWM period wrap
module step_divider #(
  parameter int N     = 8,
  parameter int PRE_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic [PRE_W-1:0] prescale_i,
  output logic             step_o,
  output logic             period_done_o
);

  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [N-1:0]     step_cnt_q, step_cnt_d;
  logic             step_q, step_d;
  logic             period_done_q, period_done_d;
  logic             strobe;

  // step_cnt advances while a step is on the wire, exactly like the
  // downstream counter, so the flag marks the step that wraps it.
  always_comb begin
    strobe        = (pre_cnt_q == prescale_i);
    pre_cnt_d     = strobe ? '0 : pre_cnt_q + PRE_W'(1);
    step_cnt_d    = step_cnt_q + {{(N-1){1'b0}}, step_q};
    step_d        = strobe;
    period_done_d = strobe && (step_cnt_d == '1);
  end

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      pre_cnt_q     <= '0;
      step_cnt_q    <= '0;
      step_q        <= 1'b0;
      period_done_q <= 1'b0;
    end else begin
      pre_cnt_q     <= pre_cnt_d;
      step_cnt_q    <= step_cnt_d;
      step_q        <= step_d;
      period_done_q <= period_done_d;
    end
  end

  assign step_o        = step_q;
  assign period_done_o = period_done_q;

endmodule

// File: rtl/pwm_fader.sv
// rtl/pwm_fader.sv - triangle duty fader with holds at both extremes
module pwm_fader #(
  parameter int N      = 8,
  parameter int PRE_W  = 16,
  parameter int HOLD_W = 8
) (
  input logic        clk,
  input logic        rst,
  pwm_fader_if.slave bus
);
  import pwm_fader_pkg::*;

  fader_state_e      state_q, state_d;
  logic [N-1:0]      duty_q, duty_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [N:0]        rise_sum, fall_diff;
  logic [N-1:0]      rise_duty, fall_duty;
  logic              step, period_done, div_clr;

  assign div_clr = !bus.ena || (state_q == ST_IDLE);

  step_divider #(
    .N     (N),
    .PRE_W (PRE_W)
  ) u_step_divider (
    .clk           (clk),
    .rst           (rst),
    .clr_i         (div_clr),
    .prescale_i    (bus.prescale),
    .step_o        (step),
    .period_done_o (period_done)
  );

  // One extra bit so saturation is judged before truncation.
  always_comb begin
    rise_sum  = {1'b0, duty_q} + {1'b0, bus.ramp_inc};
    rise_duty = (rise_sum > {1'b0, bus.duty_max}) ? bus.duty_max : rise_sum[N-1:0];
    fall_diff = {1'b0, duty_q} - {1'b0, bus.ramp_inc};
    fall_duty = fall_diff[N] ? '0 : fall_diff[N-1:0];
  end

  always_comb begin
    state_d    = state_q;
    duty_d     = duty_q;
    hold_cnt_d = hold_cnt_q;
    if (!bus.ena) begin
      state_d    = ST_IDLE;
      duty_d     = '0;
      hold_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d    = ST_RISE;
          duty_d     = '0;
          hold_cnt_d = '0;
        end
        ST_RISE: begin
          if (period_done) begin
            duty_d = rise_duty;
            if (rise_duty == bus.duty_max) begin
              state_d    = ST_HOLD_HI;
              hold_cnt_d = '0;
            end
          end
        end
        ST_HOLD_HI: begin
          if (period_done) begin
            if (duty_q > bus.duty_max) duty_d = bus.duty_max;
            if (hold_cnt_q == bus.hold_cycles) begin
              state_d    = ST_FALL;
              hold_cnt_d = '0;
            end else begin
              hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
          end
        end
        ST_FALL: begin
          if (period_done) begin
            duty_d = fall_duty;
            if (fall_duty == '0) begin
              state_d    = ST_HOLD_LO;
              hold_cnt_d = '0;
            end
          end
        end
        ST_HOLD_LO: begin
          if (period_done) begin
            if (hold_cnt_q == bus.hold_cycles) begin
              state_d    = ST_RISE;
              hold_cnt_d = '0;
            end else begin
              hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
          end
        end
        default: begin
          state_d    = ST_IDLE;
          duty_d     = '0;
          hold_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      duty_q     <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      duty_q     <= duty_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign bus.step        = step;
  assign bus.duty        = duty_q;
  assign bus.period_done = period_done;
  assign bus.phase       = state_q;

endmodule

// File: tb/tb_pwm_fader.sv
// tb/tb_pwm_fader.sv - directed and randomized bench for pwm_fader
module tb_pwm_fader;
  import pwm_fader_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pwm_fader_if #(.N(8), .PRE_W(16), .HOLD_W(8)) a ();
  pwm_fader_if #(.N(4), .PRE_W(16), .HOLD_W(8)) b ();

  pwm_fader #(.N(8), .PRE_W(16), .HOLD_W(8)) dut8 (.clk(clk), .rst(rst), .bus(a));
  pwm_fader #(.N(4), .PRE_W(16), .HOLD_W(8)) dut4 (.clk(clk), .rst(rst), .bus(b));

  // Reference: time since the enabling edge gives the step/period pattern
  // in closed form; the fade rules are applied once per completed period.
  int   m_t = 0, m_state = 0, m_duty = 0, m_hold = 0;
  int   m_rise, m_fall, m_div;
  logic exp_step, exp_pd;

  always_comb begin
    m_div    = int'(a.prescale) + 1;
    exp_step = 1'b0;
    exp_pd   = 1'b0;
    if (m_state != 0 && m_t > 0 && (m_t % m_div) == 0) begin
      exp_step = 1'b1;
      exp_pd   = ((m_t / m_div) % 256) == 0;
    end
    m_rise = (m_duty + int'(a.ramp_inc) < int'(a.duty_max)) ? m_duty + int'(a.ramp_inc) : int'(a.duty_max);
    m_fall = (m_duty > int'(a.ramp_inc)) ? m_duty - int'(a.ramp_inc) : 0;
  end

  always @(posedge clk) begin
    if (rst || !a.ena) begin
      m_state <= 0; m_duty <= 0; m_hold <= 0; m_t <= 0;
    end else if (m_state == 0) begin
      m_state <= 1; m_t <= 0;
    end else begin
      m_t <= m_t + 1;
      if (exp_pd) begin
        case (m_state)
          1: begin
            m_duty <= m_rise;
            if (m_rise == int'(a.duty_max)) begin m_state <= 2; m_hold <= 0; end
          end
          2: begin
            if (m_duty > int'(a.duty_max)) m_duty <= int'(a.duty_max);
            if (m_hold == int'(a.hold_cycles)) begin m_state <= 3; m_hold <= 0; end
            else m_hold <= m_hold + 1;
          end
          3: begin
            m_duty <= m_fall;
            if (m_fall == 0) begin m_state <= 4; m_hold <= 0; end
          end
          default: begin
            if (m_hold == int'(a.hold_cycles)) begin m_state <= 1; m_hold <= 0; end
            else m_hold <= m_hold + 1;
          end
        endcase
      end
    end
  end

  task automatic start_run(input int pre, input int inc, input int mx, input int hc);
    @(negedge clk);
    a.ena = 1'b0;
    @(negedge clk);
    a.prescale = 16'(pre); a.ramp_inc = 8'(inc); a.duty_max = 8'(mx); a.hold_cycles = 8'(hc);
    a.ena = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a.ena = 1'b1;
    b.ena = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (a.phase !== 3'd0) begin failures++; $display("FAIL reset_phase: got %0d expected 0", a.phase); end
    checks++; if (a.duty !== 8'd0) begin failures++; $display("FAIL reset_duty: got %0d expected 0", a.duty); end
    checks++; if (a.step !== 1'b0 || a.period_done !== 1'b0) begin failures++; $display("FAIL reset_strobes: got step=%0b pd=%0b expected 0,0", a.step, a.period_done); end
    checks++; if (b.phase !== 3'd0 || b.duty !== 4'd0) begin failures++; $display("FAIL reset_n4: got phase=%0d duty=%0d expected 0,0", b.phase, b.duty); end
    rst = 1'b0;
    a.ena = 1'b0;
    b.ena = 1'b0;
  endtask

  task automatic test_prescale();
    start_run(3, 1, 10, 0);
    for (int c = 0; c <= 40; c++) begin
      @(negedge clk);
      checks++;
      if (a.step !== ((c != 0) && (c % 4 == 0))) begin
        failures++; $display("FAIL prescale3_step: cycle %0d got %0b expected %0b", c, a.step, (c != 0) && (c % 4 == 0));
        break;
      end
    end
    start_run(0, 1, 10, 0);
    for (int c = 0; c <= 20; c++) begin
      @(negedge clk);
      checks++;
      if (a.step !== (c != 0)) begin
        failures++; $display("FAIL prescale0_step: cycle %0d got %0b expected %0b", c, a.step, c != 0);
        break;
      end
    end
  endtask

  task automatic test_fade_sequence();
    int   exp_duty [13] = '{64, 128, 192, 200, 200, 200, 136, 72, 8, 0, 0, 0, 64};
    int   exp_phase[13] = '{1, 1, 1, 2, 2, 3, 3, 3, 3, 4, 4, 1, 1};
    int   got_duty[$], got_phase[$];
    logic prev_pd = 1'b0;
    logic [7:0] prev_duty = 8'd0;
    logic mid_change = 1'b0;
    start_run(0, 64, 200, 1);
    for (int c = 0; c < 13 * 256 + 50 && got_duty.size() < 13; c++) begin
      @(negedge clk);
      if (prev_pd) begin
        got_duty.push_back(int'(a.duty));
        got_phase.push_back(int'(a.phase));
      end
      if (a.duty !== prev_duty && !prev_pd) mid_change = 1'b1;
      prev_pd = a.period_done;
      prev_duty = a.duty;
    end
    checks++;
    if (got_duty.size() != 13) begin
      failures++; $display("FAIL fade_periods: got %0d periods expected 13", got_duty.size());
    end else begin
      for (int i = 0; i < 13; i++) begin
        checks++;
        if (got_duty[i] != exp_duty[i] || got_phase[i] != exp_phase[i]) begin
          failures++;
          $display("FAIL fade_seq[%0d]: got duty=%0d phase=%0d expected duty=%0d phase=%0d", i, got_duty[i], got_phase[i], exp_duty[i], exp_phase[i]);
        end
      end
    end
    checks++; if (mid_change) begin failures++; $display("FAIL fade_mid_period: got duty change off period_done expected none"); end
  endtask

  task automatic test_period_n4();
    b.prescale = 16'd0; b.ramp_inc = 4'd1; b.duty_max = 4'd15; b.hold_cycles = 8'd0;
    @(negedge clk);
    b.ena = 1'b1;
    for (int c = 0; c <= 64; c++) begin
      @(negedge clk);
      checks++;
      if (b.period_done !== ((c != 0) && (c % 16 == 0))) begin
        failures++; $display("FAIL n4_period_done: cycle %0d got %0b expected %0b", c, b.period_done, (c != 0) && (c % 16 == 0));
        break;
      end
    end
    b.ena = 1'b0;
  endtask

  task automatic test_ena_drop();
    bit found = 0;
    start_run(0, 64, 200, 1);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (a.phase === 3'd3 && a.duty === 8'd136) begin found = 1; break; end
    end
    checks++;
    if (!found) begin failures++; $display("FAIL ena_drop_reach: got timeout expected FALL at 136"); return; end
    a.ena = 1'b0;
    @(negedge clk);
    checks++;
    if (a.phase !== 3'd0 || a.duty !== 8'd0 || a.step !== 1'b0 || a.period_done !== 1'b0) begin
      failures++; $display("FAIL ena_drop_idle: got phase=%0d duty=%0d step=%0b pd=%0b expected 0,0,0,0", a.phase, a.duty, a.step, a.period_done);
    end
    a.ena = 1'b1;
    @(negedge clk);
    checks++; if (a.phase !== 3'd1 || a.duty !== 8'd0) begin failures++; $display("FAIL ena_restart: got phase=%0d duty=%0d expected 1,0", a.phase, a.duty); end
    repeat (256) @(negedge clk);
    checks++; if (a.period_done !== 1'b1) begin failures++; $display("FAIL ena_restart_pd: got %0b expected 1", a.period_done); end
    @(negedge clk);
    checks++; if (a.duty !== 8'd64) begin failures++; $display("FAIL ena_restart_duty: got %0d expected 64", a.duty); end
  endtask

  task automatic test_rst_hold();
    int npd = 0;
    start_run(0, 64, 200, 1);
    for (int c = 0; c < 2000 && npd < 5; c++) begin
      @(negedge clk);
      if (a.period_done) npd++;
    end
    @(negedge clk);
    checks++;
    if (npd != 5 || a.phase !== 3'd2 || a.duty !== 8'd200) begin
      failures++; $display("FAIL rst_hold_reach: got pds=%0d phase=%0d duty=%0d expected 5,2,200", npd, a.phase, a.duty);
    end
    repeat (50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (a.phase !== 3'd0 || a.duty !== 8'd0 || a.step !== 1'b0 || a.period_done !== 1'b0) begin
      failures++; $display("FAIL rst_hold_clear: got phase=%0d duty=%0d step=%0b pd=%0b expected 0,0,0,0", a.phase, a.duty, a.step, a.period_done);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (a.phase !== 3'd1) begin failures++; $display("FAIL rst_restart_phase: got %0d expected 1", a.phase); end
    repeat (255) @(negedge clk);
    checks++; if (a.period_done !== 1'b0) begin failures++; $display("FAIL rst_residue_early: got pd=%0b expected 0", a.period_done); end
    @(negedge clk);
    checks++; if (a.period_done !== 1'b1) begin failures++; $display("FAIL rst_residue_pd: got pd=%0b expected 1", a.period_done); end
    start_run(0, 64, 0, 1);
    repeat (258) @(negedge clk);
    checks++; if (a.phase !== 3'd2 || a.duty !== 8'd0) begin failures++; $display("FAIL max0_hold: got phase=%0d duty=%0d expected 2,0", a.phase, a.duty); end
  endtask

  task automatic test_live_ceiling();
    bit found = 0;
    bit pd_seen = 0;
    start_run(0, 64, 200, 3);
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (a.phase === 3'd2) begin found = 1; break; end
    end
    checks++;
    if (!found) begin failures++; $display("FAIL ceiling_reach: got timeout expected HOLD_HI"); return; end
    repeat (100) @(negedge clk);
    a.duty_max = 8'd100;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (a.duty !== 8'd200) begin
        checks++; failures++; $display("FAIL ceiling_mid_period: got duty=%0d expected 200", a.duty);
        break;
      end
      if (a.period_done) begin pd_seen = 1; break; end
    end
    checks++; if (!pd_seen) begin failures++; $display("FAIL ceiling_pd: got timeout expected period_done"); end
    @(negedge clk);
    checks++; if (a.duty !== 8'd100 || a.phase !== 3'd2) begin failures++; $display("FAIL ceiling_clamp: got duty=%0d phase=%0d expected 100,2", a.duty, a.phase); end
  endtask

  task automatic test_random();
    for (int run = 0; run < 4; run++) begin
      start_run($urandom_range(0, 1), ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 120),
                $urandom_range(0, 255), $urandom_range(0, 2));
      for (int c = 0; c < 4000; c++) begin
        @(negedge clk);
        checks++;
        if (a.phase !== 3'(m_state) || a.duty !== 8'(m_duty) || a.step !== exp_step || a.period_done !== exp_pd) begin
          failures++;
          $display("FAIL random_run%0d cycle %0d: got phase=%0d duty=%0d step=%0b pd=%0b expected phase=%0d duty=%0d step=%0b pd=%0b",
                   run, c, a.phase, a.duty, a.step, a.period_done, m_state, m_duty, exp_step, exp_pd);
          break;
        end
        if ($urandom_range(0, 599) == 0) a.duty_max = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 599) == 0) a.ramp_inc = 8'($urandom_range(0, 120));
        a.ena = ($urandom_range(0, 1499) != 0);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    a.ena = 1'b0; a.prescale = '0; a.ramp_inc = '0; a.duty_max = '0; a.hold_cycles = '0;
    b.ena = 1'b0; b.prescale = '0; b.ramp_inc = '0; b.duty_max = '0; b.hold_cycles = '0;
    test_reset();
    test_prescale();
    test_fade_sequence();
    test_period_n4();
    test_ena_drop();
    test_rst_hold();
    test_live_ceiling();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pwm_fader.md
PWM_FADER -- requirements
Module: pwm_fader

Interface
REQ-001 Parameter N, default 8, duty width; matches the downstream PWM counter width.
REQ-002 Parameter PRE_W, default 16, prescaler width.
REQ-003 Parameter HOLD_W, default 8, hold-counter width.
REQ-004 clk  input  1  clock, all state changes on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 ena  input  1  run enable; low forces IDLE.
REQ-007 prescale  input  PRE_W  step strobe period minus one, in clk cycles.
REQ-008 ramp_inc  input  N  duty change per PWM period while ramping.
REQ-009 duty_max  input  N  ramp ceiling.
REQ-010 hold_cycles  input  HOLD_W  extra PWM periods held at each extreme.
REQ-011 step  output  1  registered one-clk strobe that advances the downstream PWM counter.
REQ-012 duty  output  N  registered duty value for the downstream PWM.
REQ-013 period_done  output  1  registered one-clk strobe on the step that wraps the PWM period.
REQ-014 phase  output  3  current state encoding.

Function
REQ-015 States: IDLE, RISE, HOLD_HI, FALL, HOLD_LO.
REQ-016 Prescaler: while not IDLE, pre_cnt increments each clk; when pre_cnt == prescale, pre_cnt returns to 0 and step is high the next cycle; prescale=0 gives step high every cycle.
REQ-017 Step counter: N-bit step_cnt increments on each step pulse and wraps 2^N-1 -> 0, mirroring the downstream PWM counter.
REQ-018 period_done is high in the same cycle as the step pulse that takes step_cnt from 2^N-1 to 0; the period is 2^N steps.
REQ-019 duty, state and hold_cnt change only on a period_done cycle, so the PWM never sees a mid-period duty change; exception: ena low (REQ-025).
REQ-020 IDLE -> RISE on the first edge where ena is sampled high; duty=0, pre_cnt=0, step_cnt=0, hold_cnt=0 on entry.
REQ-021 RISE: on period_done, duty <= min(duty+ramp_inc, duty_max), computed in N+1 bits; if the result equals duty_max -> HOLD_HI.
REQ-022 FALL: on period_done, duty <= max(duty-ramp_inc, 0), computed in N+1 bits; if the result is 0 -> HOLD_LO.
REQ-023 HOLD_HI/HOLD_LO: hold_cnt cleared on entry; on period_done, if hold_cnt == hold_cycles, exit (HOLD_HI->FALL, HOLD_LO->RISE); else hold_cnt++. The hold lasts hold_cycles+1 periods.
REQ-024 In HOLD_HI, if duty > duty_max at period_done, duty <= duty_max (live ceiling change).
REQ-025 ena sampled low in any state: next edge -> IDLE, duty=0, step=0, period_done=0, all counters 0; same-cycle period_done is ignored.
REQ-026 ramp_inc=0: duty is frozen; RISE persists unless duty == duty_max; FALL persists unless duty == 0.
REQ-027 duty_max=0: RISE -> HOLD_HI at first period_end with duty 0.
REQ-028 prescale, ramp_inc, duty_max and hold_cycles are sampled at point of use and are not latched.
REQ-029 phase encoding: IDLE=0, RISE=1, HOLD_HI=2, FALL=3, HOLD_LO=4.

Reset
REQ-030 rst: state=IDLE, duty=0, step=0, period_done=0, pre_cnt=0, step_cnt=0, hold_cnt=0 at next edge.
REQ-031 rst has priority over ena; rst mid-ramp gives the full REQ-030 state, with no partial-period residue.

Structure
REQ-032 Package pwm_fader_pkg holds the state enum typedef (3-bit, REQ-029 values).
REQ-033 Sub-module step_divider (prescaler + step/step_cnt/period_done generation); the FSM and duty arithmetic live in pwm_fader.

Verification (N=8 unless noted)
REQ-034 prescale=3, ena=1 -> step high 1 of every 4 clks, first pulse 4 cycles after the enabling edge; prescale=0 -> step every clk.
REQ-035 prescale=0, ramp_inc=64, duty_max=200, hold_cycles=1 -> duty sequence 0,64,128,192,200 (HOLD_HI for 2 periods),136,72,8,0 (HOLD_LO for 2 periods),64; every change coincides with period_done.
REQ-036 N=4, prescale=0 -> period_done every 16 clks, aligned to step_cnt 15->0.
REQ-037 ena dropped mid-FALL at duty=136 -> next cycle phase=0, duty=0, step=0; ena re-raised -> restart in RISE from 0.
REQ-038 rst asserted in HOLD_HI with hold_cnt=1 -> all outputs 0 next cycle; duty_max=0 case -> HOLD_HI after one period with duty 0.
REQ-039 duty_max lowered 200->100 during HOLD_HI -> duty=100 at next period_done, never mid-period.
